// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : audio_pkg
//  Purpose  : Shared types, constants and helpers for the I2S stream
//             processor: channel-mode encoding, frame geometry defaults and
//             the clamped arithmetic right shift used for attenuation.
//  Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_SWAP = 2'b01,
        MODE_MONO = 2'b10,
        MODE_MUTE = 2'b11
    } mode_e;

    localparam int DEF_SLOT_W = 32;
    localparam int FRAME_BITS = 2 * DEF_SLOT_W;

    // Working width of sat_shift; any sample up to 31 bits is sign-extended
    // into this width by the caller and truncated back afterwards.
    localparam int SHIFT_W = 32;

    // Arithmetic right shift that saturates to pure sign bits once the shift
    // reaches the full working width, so huge atten values stay well defined.
    function automatic logic signed [SHIFT_W-1:0] sat_shift(
        input logic signed [SHIFT_W-1:0] sample,
        input logic        [SHIFT_W-1:0] shamt
    );
        if (shamt >= SHIFT_W'(SHIFT_W - 1)) begin
            return {SHIFT_W{sample[SHIFT_W-1]}};
        end
        return sample >>> shamt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_clkgen
//  Purpose  : Derives SCLK and LRCLK from MCLK and publishes the edge strobes,
//             frame boundary and slot bit index used by the data path.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_clkgen #(
    parameter int SLOT_W        = 32,
    parameter int MCLK_PER_SCLK = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              o_sclk,
    output logic                              o_lrclk,
    output logic                              o_sclk_rise,
    output logic                              o_sclk_fall,
    output logic                              o_frame_start,
    output logic [$clog2(2*SLOT_W)-1:0]       o_slot_idx,
    output logic [$clog2(2*SLOT_W)-1:0]       o_slot_idx_next,
    output logic                              o_lrclk_next
);

    localparam int c_HALF       = MCLK_PER_SCLK / 2;
    localparam int c_DIV_W      = $clog2(MCLK_PER_SCLK);
    localparam int c_FRAME_BITS = 2 * SLOT_W;
    localparam int c_BIT_W      = $clog2(c_FRAME_BITS);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_sclk;
    logic               r_lrclk;

    logic [c_DIV_W-1:0] w_div_next;
    logic [c_BIT_W-1:0] w_bit_adv;
    logic               w_frame_wrap;

    assign o_sclk_rise  = (r_div_cnt == c_DIV_W'(c_HALF - 1));
    assign o_sclk_fall  = (r_div_cnt == c_DIV_W'(MCLK_PER_SCLK - 1));
    assign w_frame_wrap = (r_bit_cnt == c_BIT_W'(c_FRAME_BITS - 1));
    assign w_div_next   = o_sclk_fall ? '0 : r_div_cnt + c_DIV_W'(1);
    assign w_bit_adv    = w_frame_wrap ? '0 : r_bit_cnt + c_BIT_W'(1);

    assign o_frame_start   = o_sclk_fall && w_frame_wrap;
    assign o_lrclk_next    = (w_bit_adv >= c_BIT_W'(SLOT_W));
    assign o_slot_idx      = r_lrclk ? r_bit_cnt - c_BIT_W'(SLOT_W) : r_bit_cnt;
    assign o_slot_idx_next = o_lrclk_next ? w_bit_adv - c_BIT_W'(SLOT_W) : w_bit_adv;

    assign o_sclk  = r_sclk;
    assign o_lrclk = r_lrclk;

    // MCLK divider and bit counter; sclk/lrclk are registered from the
    // next-state counter values so they change on the same edge as the counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sclk    <= 1'b0;
            r_lrclk   <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_sclk    <= (w_div_next >= c_DIV_W'(c_HALF));
            if (o_sclk_fall) begin
                r_bit_cnt <= w_bit_adv;
                r_lrclk   <= o_lrclk_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_stream_proc.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_stream_proc
//  Purpose  : Stereo I2S receiver / processor / transmitter. Received frames
//             are remixed (pass, swap, mono, mute), attenuated by an
//             arithmetic shift and retransmitted one frame later.
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_stream_proc
    import audio_pkg::*;
#(
    parameter int DATA_W        = 24,
    parameter int SLOT_W        = 32,
    parameter int MCLK_PER_SCLK = 8,
    parameter int ATTEN_W       = 5
) (
    input  logic               mclk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [ATTEN_W-1:0] atten,
    input  logic               serial_in,
    output logic               sclk,
    output logic               lrclk,
    output logic               serial_out,
    output logic               frame_valid,
    output logic [DATA_W-1:0]  o_left,
    output logic [DATA_W-1:0]  o_right
);

    localparam int c_BIT_W = $clog2(2 * SLOT_W);

    logic               w_sclk_rise;
    logic               w_sclk_fall;
    logic               w_frame_start;
    logic               w_lrclk_next;
    logic [c_BIT_W-1:0] w_slot;
    logic [c_BIT_W-1:0] w_slot_next;

    logic [DATA_W-1:0]  r_rx_left;
    logic [DATA_W-1:0]  r_rx_right;
    logic [DATA_W-1:0]  r_tx_left;
    logic [DATA_W-1:0]  r_tx_right;
    logic [DATA_W-1:0]  r_out_left;
    logic [DATA_W-1:0]  r_out_right;
    logic               r_serial_out;
    logic               r_frame_valid;

    logic               w_rx_bit;
    logic               w_tx_bit_next;
    logic [DATA_W:0]    w_sum;
    logic [DATA_W-1:0]  w_mono;
    logic [DATA_W-1:0]  w_proc_l;
    logic [DATA_W-1:0]  w_proc_r;
    logic [SHIFT_W-1:0] w_ext_l;
    logic [SHIFT_W-1:0] w_ext_r;
    logic [SHIFT_W-1:0] w_shift_l;
    logic [SHIFT_W-1:0] w_shift_r;
    logic               w_unused_bits;

    i2s_clkgen #(
        .SLOT_W        (SLOT_W),
        .MCLK_PER_SCLK (MCLK_PER_SCLK)
    ) u_clkgen (
        .clk             (mclk),
        .rst             (reset),
        .o_sclk          (sclk),
        .o_lrclk         (lrclk),
        .o_sclk_rise     (w_sclk_rise),
        .o_sclk_fall     (w_sclk_fall),
        .o_frame_start   (w_frame_start),
        .o_slot_idx      (w_slot),
        .o_slot_idx_next (w_slot_next),
        .o_lrclk_next    (w_lrclk_next)
    );

    // Sample data occupies slot bits 1..DATA_W (one-bit I2S delay after LRCLK).
    assign w_rx_bit      = (w_slot >= c_BIT_W'(1)) && (w_slot <= c_BIT_W'(DATA_W));
    assign w_tx_bit_next = (w_slot_next >= c_BIT_W'(1)) && (w_slot_next <= c_BIT_W'(DATA_W));

    // Mono average: sign-extend by one bit so L+R never wraps, then halve.
    assign w_sum  = {r_rx_left[DATA_W-1], r_rx_left} + {r_rx_right[DATA_W-1], r_rx_right};
    assign w_mono = w_sum[DATA_W:1];

    // Channel remix on the just-completed frame, using the mode present at
    // the frame boundary.
    always_comb begin
        w_proc_l = r_rx_left;
        w_proc_r = r_rx_right;
        case (mode_e'(mode))
            MODE_PASS: begin
                w_proc_l = r_rx_left;
                w_proc_r = r_rx_right;
            end
            MODE_SWAP: begin
                w_proc_l = r_rx_right;
                w_proc_r = r_rx_left;
            end
            MODE_MONO: begin
                w_proc_l = w_mono;
                w_proc_r = w_mono;
            end
            MODE_MUTE: begin
                w_proc_l = '0;
                w_proc_r = '0;
            end
            default: begin
                w_proc_l = '0;
                w_proc_r = '0;
            end
        endcase
    end

    assign w_ext_l   = {{(SHIFT_W-DATA_W){w_proc_l[DATA_W-1]}}, w_proc_l};
    assign w_ext_r   = {{(SHIFT_W-DATA_W){w_proc_r[DATA_W-1]}}, w_proc_r};
    assign w_shift_l = sat_shift(w_ext_l, SHIFT_W'(atten));
    assign w_shift_r = sat_shift(w_ext_r, SHIFT_W'(atten));

    // Upper shift bits are pure sign copies and the sum LSB is dropped by the halving.
    assign w_unused_bits = ^{w_sum[0], w_shift_l[SHIFT_W-1:DATA_W], w_shift_r[SHIFT_W-1:DATA_W]};

    // Receive shifters: MSB-first capture on SCLK rising edges into the
    // channel selected by LRCLK.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_rx_left  <= '0;
            r_rx_right <= '0;
        end else if (w_sclk_rise && w_rx_bit) begin
            if (lrclk) begin
                r_rx_right <= {r_rx_right[DATA_W-2:0], serial_in};
            end else begin
                r_rx_left  <= {r_rx_left[DATA_W-2:0], serial_in};
            end
        end
    end

    // Frame-boundary capture of the received pair and the valid pulse.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_out_left    <= '0;
            r_out_right   <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_frame_start;
            if (w_frame_start) begin
                r_out_left  <= r_rx_left;
                r_out_right <= r_rx_right;
            end
        end
    end

    // Transmit shifters: load processed samples at the boundary, then present
    // the bit for the upcoming slot position on each SCLK falling edge.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_tx_left    <= '0;
            r_tx_right   <= '0;
            r_serial_out <= 1'b0;
        end else if (w_frame_start) begin
            r_tx_left    <= w_shift_l[DATA_W-1:0];
            r_tx_right   <= w_shift_r[DATA_W-1:0];
            r_serial_out <= 1'b0;
        end else if (w_sclk_fall) begin
            if (w_tx_bit_next) begin
                if (w_lrclk_next) begin
                    r_serial_out <= r_tx_right[DATA_W-1];
                    r_tx_right   <= {r_tx_right[DATA_W-2:0], 1'b0};
                end else begin
                    r_serial_out <= r_tx_left[DATA_W-1];
                    r_tx_left    <= {r_tx_left[DATA_W-2:0], 1'b0};
                end
            end else begin
                r_serial_out <= 1'b0;
            end
        end
    end

    assign serial_out  = r_serial_out;
    assign frame_valid = r_frame_valid;
    assign o_left      = r_out_left;
    assign o_right     = r_out_right;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stream_proc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_stream_proc
//  Purpose  : Directed self-checking bench for i2s_stream_proc at default
//             parameters (24-bit samples, 32-bit slots, MCLK/8 bit clock).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_stream_proc;

    logic        mclk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [4:0]  atten;
    logic        serial_in = 1'b0;
    logic        sclk;
    logic        lrclk;
    logic        serial_out;
    logic        frame_valid;
    logic [23:0] o_left;
    logic [23:0] o_right;

    logic [23:0] in_l;
    logic [23:0] in_r;
    logic [63:0] cap = '0;
    int          m_div = 0;
    int          m_bit = 0;
    int          checks = 0;
    int          errors = 0;

    i2s_stream_proc #(
        .DATA_W        (24),
        .SLOT_W        (32),
        .MCLK_PER_SCLK (8),
        .ATTEN_W       (5)
    ) dut (
        .mclk        (mclk),
        .reset       (reset),
        .mode        (mode),
        .atten       (atten),
        .serial_in   (serial_in),
        .sclk        (sclk),
        .lrclk       (lrclk),
        .serial_out  (serial_out),
        .frame_valid (frame_valid),
        .o_left      (o_left),
        .o_right     (o_right)
    );

    always #5 mclk = ~mclk;

    // Reference bit-clock position: div 0..7, frame bit 0..63.
    always @(posedge mclk) begin
        if (reset) begin
            m_div <= 0;
            m_bit <= 0;
        end else begin
            m_div <= (m_div == 7) ? 0 : m_div + 1;
            if (m_div == 7) m_bit <= (m_bit == 63) ? 0 : m_bit + 1;
        end
    end

    // ADC stand-in: present slot bit 1..24 of the current channel, MSB first.
    always @(negedge mclk) begin
        int b;
        b = m_bit % 32;
        if (b >= 1 && b <= 24) serial_in = (m_bit >= 32) ? in_r[24-b] : in_l[24-b];
        else                   serial_in = 1'b0;
    end

    // DAC stand-in: sample serial_out mid-period of each bit position.
    always @(negedge mclk) begin
        if (m_div == 4) cap[m_bit] = serial_out;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frame_bits(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] v;
        v = '0;
        for (int b = 1; b <= 24; b++) begin
            v[b]      = l[24-b];
            v[32 + b] = r[24-b];
        end
        return v;
    endfunction

    task automatic boundary(input string tag, input logic [23:0] rl, input logic [23:0] rr,
                            input logic [23:0] tl, input logic [23:0] tr);
        chk({tag, "_fv"},    64'(frame_valid), 64'd1);
        chk({tag, "_left"},  64'(o_left),      64'(rl));
        chk({tag, "_right"}, 64'(o_right),     64'(rr));
        chk({tag, "_txbits"}, cap,             frame_bits(tl, tr));
    endtask

    initial begin
        reset = 1'b1;
        mode  = 2'b00;
        atten = 5'd0;
        in_l  = 24'h123456;
        in_r  = 24'hABCDEF;
        tick(10);
        chk("rst_sclk",  64'(sclk),        64'd0);
        chk("rst_lrclk", 64'(lrclk),       64'd0);
        chk("rst_sout",  64'(serial_out),  64'd0);
        chk("rst_fv",    64'(frame_valid), 64'd0);
        chk("rst_left",  64'(o_left),      64'd0);
        chk("rst_right", 64'(o_right),     64'd0);
        reset = 1'b0;

        // Clock geometry after release.
        tick(3);   chk("sclk_e3",  64'(sclk), 64'd0);
        tick(1);   chk("sclk_e4",  64'(sclk), 64'd1);
        tick(4);   chk("sclk_e8",  64'(sclk), 64'd0);
        tick(4);   chk("sclk_e12", 64'(sclk), 64'd1);
        tick(243); chk("lr_e255",  64'(lrclk), 64'd0);
        tick(1);   chk("lr_e256",  64'(lrclk), 64'd1);
        tick(255); chk("fv_e511",  64'(frame_valid), 64'd0);

        // Frame 0: pass; first frame after reset transmits zeros.
        tick(1);   boundary("f0", 24'h123456, 24'hABCDEF, 24'h0, 24'h0);
        chk("lr_e512", 64'(lrclk), 64'd0);
        tick(1);   chk("fv_e513", 64'(frame_valid), 64'd0);

        // Frame 1: swap.
        mode = 2'b01;
        tick(511); boundary("f1_swap", 24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF);

        // Frames 2..4: mono.
        mode = 2'b10; in_l = 24'h7FFFFF; in_r = 24'h7FFFFF;
        tick(512); boundary("f2_mono", 24'h7FFFFF, 24'h7FFFFF, 24'hABCDEF, 24'h123456);
        in_l = 24'h800000; in_r = 24'h000000;
        tick(512); boundary("f3_mono", 24'h800000, 24'h000000, 24'h7FFFFF, 24'h7FFFFF);
        in_l = 24'h800000; in_r = 24'h800000;
        tick(512); boundary("f4_mono", 24'h800000, 24'h800000, 24'hC00000, 24'hC00000);

        // Frames 5..7: attenuation.
        mode = 2'b00; atten = 5'd4; in_l = 24'h800000; in_r = 24'h400000;
        tick(512); boundary("f5_att4", 24'h800000, 24'h400000, 24'h800000, 24'h800000);
        atten = 5'd31; in_l = 24'h400000; in_r = 24'h800000;
        tick(512); boundary("f6_att31", 24'h400000, 24'h800000, 24'hF80000, 24'h040000);
        mode = 2'b01; atten = 5'd1; in_l = 24'h123456; in_r = 24'hABCDEF;
        tick(512); boundary("f7_swapatt", 24'h123456, 24'hABCDEF, 24'h000000, 24'hFFFFFF);

        // Frame 8: pass at start, switched to mute at bit_cnt 20.
        mode = 2'b00; atten = 5'd0; in_l = 24'h654321; in_r = 24'h0F0F0F;
        tick(160); mode = 2'b11;
        tick(352); boundary("f8_midmode", 24'h654321, 24'h0F0F0F, 24'hD5E6F7, 24'h091A2B);

        // Frame 9: mute output, then reset at bit_cnt 40.
        mode = 2'b00; in_l = 24'h111111; in_r = 24'h222222;
        tick(320);
        chk("f9_mute_bits", 64'(cap[39:0]), 64'd0);
        chk("f9_lr_bit40",  64'(lrclk), 64'd1);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_left",  64'(o_left),      64'd0);
        chk("mid_rst_right", 64'(o_right),     64'd0);
        chk("mid_rst_lrclk", 64'(lrclk),       64'd0);
        chk("mid_rst_sclk",  64'(sclk),        64'd0);
        chk("mid_rst_sout",  64'(serial_out),  64'd0);
        chk("mid_rst_fv",    64'(frame_valid), 64'd0);
        in_l = 24'h0F0F0F; in_r = 24'h707070;
        tick(4);
        reset = 1'b0;
        tick(3);   chk("rst2_sclk_e3", 64'(sclk), 64'd0);
        tick(1);   chk("rst2_sclk_e4", 64'(sclk), 64'd1);

        // Frames 10..11: restart from zero counters; zeros first, then data.
        tick(508); boundary("f10_restart", 24'h0F0F0F, 24'h707070, 24'h0, 24'h0);
        tick(512); boundary("f11_pass", 24'h0F0F0F, 24'h707070, 24'h0F0F0F, 24'h707070);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
